// File: rtl/led_shift_tx.sv
// Serial transmitter for a 74HC595-style LED chain: shifts a parallel pattern out MSB first, then latches it.
// Latency: busy = 2*CLK_DIV*WIDTH + CLK_DIV cycles from the cycle after load; done pulses in the first idle cycle.
// Backpressure: load is accepted only while idle (busy=0); requests during a frame are dropped, never queued.
module led_shift_tx #(
   parameter int WIDTH   = 8,
   parameter int CLK_DIV = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] led_data,
   input  logic             load,
   output logic             busy,
   output logic             done,
   output logic             ser_clk,
   output logic             ser_data,
   output logic             ser_latch
);

   // Counter widths are sized so neither counter can wrap within a frame.
   localparam int PW = $clog2(CLK_DIV + 1);
   localparam int BW = $clog2(WIDTH + 1);

   localparam logic [PW-1:0] PH_LAST   = PW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_FIRST = BW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT_LO = 2'd1,
      SHIFT_HI = 2'd2,
      LATCH    = 2'd3
   } state_t;

   state_t           state;
   logic [PW-1:0]    phase;
   logic [BW-1:0]    bit_cnt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_next;
   logic             phase_end;

   // Next shift-register contents; the new MSB is driven onto ser_data
   // in the same edge that enters SHIFT_LO, so data is stable for the whole
   // low phase and the chain sees it settled at the ser_clk rise.
   assign shreg_next = shreg << 1;

   // Every timed state lasts exactly CLK_DIV cycles.
   assign phase_end = (phase == PH_LAST);

   // Frame sequencer: state, counters and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         phase     <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ser_clk   <= 1'b0;
         ser_data  <= 1'b0;
         ser_latch <= 1'b0;
      end else begin
         // done is a single-cycle strobe unless LATCH finishes this edge.
         done <= 1'b0;

         case (state)
            IDLE: begin
               ser_clk   <= 1'b0;
               ser_latch <= 1'b0;
               ser_data  <= 1'b0;
               phase     <= '0;
               if (load) begin
                  // Pattern is captured once; later led_data changes cannot
                  // disturb the frame in flight.
                  shreg    <= led_data;
                  bit_cnt  <= BIT_FIRST;
                  ser_data <= led_data[WIDTH-1];
                  busy     <= 1'b1;
                  state    <= SHIFT_LO;
               end
            end

            SHIFT_LO: begin
               if (phase_end) begin
                  phase   <= '0;
                  ser_clk <= 1'b1;
                  state   <= SHIFT_HI;
               end else begin
                  phase <= phase + PW'(1);
               end
            end

            SHIFT_HI: begin
               if (phase_end) begin
                  phase   <= '0;
                  ser_clk <= 1'b0;
                  if (bit_cnt == '0) begin
                     // Last bit clocked in: drop data and raise the latch.
                     ser_data  <= 1'b0;
                     ser_latch <= 1'b1;
                     state     <= LATCH;
                  end else begin
                     bit_cnt  <= bit_cnt - BW'(1);
                     shreg    <= shreg_next;
                     ser_data <= shreg_next[WIDTH-1];
                     state    <= SHIFT_LO;
                  end
               end else begin
                  phase <= phase + PW'(1);
               end
            end

            LATCH: begin
               if (phase_end) begin
                  phase     <= '0;
                  ser_latch <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= IDLE;
               end else begin
                  phase <= phase + PW'(1);
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_shift_tx.sv
// Directed bench for led_shift_tx: one 8-bit/div-2 instance and one 4-bit/div-1 instance.
// Outputs are observed on the falling clock edge; stimulus changes just after it.
module tb_led_shift_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       load [2];
   logic [7:0] data0;
   logic [3:0] data1;
   logic       busy [2];
   logic       done [2];
   logic       sclk [2];
   logic       sdat [2];
   logic       slat [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   led_shift_tx #(.WIDTH(8), .CLK_DIV(2)) u_w8 (
      .clk(clk), .rst(rst), .led_data(data0), .load(load[0]),
      .busy(busy[0]), .done(done[0]), .ser_clk(sclk[0]),
      .ser_data(sdat[0]), .ser_latch(slat[0])
   );

   led_shift_tx #(.WIDTH(4), .CLK_DIV(1)) u_w4 (
      .clk(clk), .rst(rst), .led_data(data1), .load(load[1]),
      .busy(busy[1]), .done(done[1]), .ser_clk(sclk[1]),
      .ser_data(sdat[1]), .ser_latch(slat[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- monitor ----------------
   int          cyc = 0;
   logic [31:0] bits [2];
   int nbits [2], rise_cyc [2], rise_gap [2];
   int nlatch [2], latch_run [2], last_latch [2], latch_start [2];
   int busy_run [2], last_busy [2], frames [2], idle_run [2], last_gap [2];
   int ndone [2], done_busy [2], done_long [2], done_cyc [2], period [2];
   logic sclk_q [2], done_q [2];

   task automatic clear_mon(input int i);
      bits[i] = '0; nbits[i] = 0; rise_gap[i] = 0;
      nlatch[i] = 0; last_latch[i] = 0; last_busy[i] = 0;
      frames[i] = 0; last_gap[i] = 0; ndone[i] = 0;
      done_busy[i] = 0; done_long[i] = 0; done_cyc[i] = 0; period[i] = 0;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         clear_mon(i);
         sclk_q[i] = 1'b0; done_q[i] = 1'b0;
         busy_run[i] = 0; idle_run[i] = 0; latch_run[i] = 0;
         rise_cyc[i] = 0; latch_start[i] = 0;
      end
   end

   always @(negedge clk) begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (sclk[i] === 1'b1 && sclk_q[i] === 1'b0) begin
            bits[i] = {bits[i][30:0], sdat[i]};
            if (nbits[i] > 0) rise_gap[i] = cyc - rise_cyc[i];
            nbits[i]++;
            rise_cyc[i] = cyc;
         end
         sclk_q[i] = sclk[i];

         if (slat[i] === 1'b1) begin
            if (latch_run[i] == 0) latch_start[i] = cyc;
            latch_run[i]++;
            nlatch[i]++;
         end else if (latch_run[i] != 0) begin
            last_latch[i] = latch_run[i];
            latch_run[i] = 0;
         end

         if (busy[i] === 1'b1) begin
            if (busy_run[i] == 0 && idle_run[i] > 0) last_gap[i] = idle_run[i];
            idle_run[i] = 0;
            busy_run[i]++;
         end else begin
            if (busy_run[i] > 0) begin
               last_busy[i] = busy_run[i];
               frames[i]++;
               busy_run[i] = 0;
            end
            idle_run[i]++;
         end

         if (done[i] === 1'b1) begin
            ndone[i]++;
            if (busy[i] !== 1'b0) done_busy[i]++;
            if (done_q[i] === 1'b1) done_long[i]++;
            if (done_cyc[i] != 0) period[i] = cyc - done_cyc[i];
            done_cyc[i] = cyc;
         end
         done_q[i] = done[i];
      end
   end

   // ---------------- helpers ----------------
   task automatic wait_done(input int i, input int limit, input string tag);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < limit && !seen; k++) begin
         @(negedge clk); #1;
         if (done[i] === 1'b1) seen = 1'b1;
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   task automatic pulse0(input logic [7:0] d);
      load[0] = 1'b1; data0 = d;
      @(negedge clk); #1;
      load[0] = 1'b0;
   endtask

   task automatic pulse1(input logic [3:0] d);
      load[1] = 1'b1; data1 = d;
      @(negedge clk); #1;
      load[1] = 1'b0;
   endtask

   task automatic check_quiet(input int i, input string tag);
      check({tag, "_busy"},  32'(busy[i]), 32'd0);
      check({tag, "_done"},  32'(done[i]), 32'd0);
      check({tag, "_sclk"},  32'(sclk[i]), 32'd0);
      check({tag, "_sdat"},  32'(sdat[i]), 32'd0);
      check({tag, "_latch"}, 32'(slat[i]), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      load[0] = 1'b0; load[1] = 1'b0;
      data0 = '0; data1 = '0;
      repeat (3) @(negedge clk); #1;
      check_quiet(0, "rst_w8");
      check_quiet(1, "rst_w4");
      rst = 1'b0;
      @(negedge clk); #1;

      // Test 1: 0xA5 on the 8-bit/div-2 instance.
      clear_mon(0);
      pulse0(8'hA5);
      check("t1_busy_start", 32'(busy[0]), 32'd1);
      check("t1_sdat_msb", 32'(sdat[0]), 32'd1);
      wait_done(0, 100, "t1_done_seen");
      check("t1_done_not_busy", 32'(busy[0]), 32'd0);
      check("t1_bits", bits[0][7:0], 32'hA5);
      check("t1_rises", 32'(nbits[0]), 32'd8);
      check("t1_rise_gap", 32'(rise_gap[0]), 32'd4);
      check("t1_busy_len", 32'(last_busy[0]), 32'd34);
      check("t1_latch_len", 32'(last_latch[0]), 32'd2);
      check("t1_latch_after_rise", 32'(latch_start[0] - rise_cyc[0]), 32'd2);
      @(negedge clk); #1;
      check("t1_done_1cycle", 32'(done[0]), 32'd0);
      check("t1_done_count", 32'(ndone[0]), 32'd1);

      // Test 2: load 0xFF mid-frame is ignored, data change has no effect.
      clear_mon(0);
      pulse0(8'hA5);
      repeat (10) @(negedge clk); #1;
      load[0] = 1'b1; data0 = 8'hFF;
      @(negedge clk); #1;
      load[0] = 1'b0; data0 = 8'h00;
      wait_done(0, 100, "t2_done_seen");
      repeat (40) @(negedge clk); #1;
      check("t2_bits", bits[0][7:0], 32'hA5);
      check("t2_rises", 32'(nbits[0]), 32'd8);
      check("t2_done_count", 32'(ndone[0]), 32'd1);
      check("t2_frames", 32'(frames[0]), 32'd1);

      // Test 3: reset after the third rise of 0x3C aborts the frame.
      clear_mon(0);
      pulse0(8'h3C);
      for (int k = 0; k < 100 && nbits[0] < 3; k++) begin
         @(negedge clk); #1;
      end
      check("t3_rises_before_rst", 32'(nbits[0]), 32'd3);
      check("t3_bits_before_rst", bits[0][2:0], 32'h1);
      check("t3_sclk_high_before_rst", 32'(sclk[0]), 32'd1);
      rst = 1'b1;
      #1;
      check_quiet(0, "t3_in_rst");
      @(negedge clk); @(negedge clk); #1;
      check("t3_no_latch", 32'(nlatch[0]), 32'd0);
      check("t3_no_done", 32'(ndone[0]), 32'd0);
      clear_mon(0);
      rst = 1'b0;
      pulse0(8'hC3);
      check("t3_accept_first_edge", 32'(busy[0]), 32'd1);
      wait_done(0, 100, "t3_done_seen");
      check("t3_bits", bits[0][7:0], 32'hC3);
      check("t3_rises", 32'(nbits[0]), 32'd8);
      check("t3_done_count", 32'(ndone[0]), 32'd1);

      // Test 4: back-to-back, second load in the done cycle.
      @(negedge clk); #1;
      clear_mon(0);
      pulse0(8'h81);
      wait_done(0, 100, "t4_done1_seen");
      pulse0(8'h7E);
      check("t4_second_accepted", 32'(busy[0]), 32'd1);
      wait_done(0, 100, "t4_done2_seen");
      check("t4_bits", bits[0][15:0], 32'h817E);
      check("t4_rises", 32'(nbits[0]), 32'd16);
      check("t4_done_count", 32'(ndone[0]), 32'd2);
      check("t4_frames", 32'(frames[0]), 32'd2);
      check("t4_idle_gap", 32'(last_gap[0]), 32'd1);
      check("t4_busy_len", 32'(last_busy[0]), 32'd34);

      // Test 5: 4-bit/div-1 instance, 0x0 then 0xF.
      clear_mon(1);
      pulse1(4'h0);
      wait_done(1, 50, "t5_done0_seen");
      check("t5_bits0", bits[1][3:0], 32'h0);
      check("t5_rises0", 32'(nbits[1]), 32'd4);
      check("t5_busy0", 32'(last_busy[1]), 32'd9);
      check("t5_latch0", 32'(last_latch[1]), 32'd1);
      check("t5_rise_gap0", 32'(rise_gap[1]), 32'd2);
      check("t5_latch_after_rise0", 32'(latch_start[1] - rise_cyc[1]), 32'd1);
      @(negedge clk); #1;
      clear_mon(1);
      pulse1(4'hF);
      wait_done(1, 50, "t5_doneF_seen");
      check("t5_bitsF", bits[1][3:0], 32'hF);
      check("t5_risesF", 32'(nbits[1]), 32'd4);
      check("t5_busyF", 32'(last_busy[1]), 32'd9);
      check("t5_latchF", 32'(last_latch[1]), 32'd1);
      check("t5_doneF_count", 32'(ndone[1]), 32'd1);

      // Test 6: load held high, frames repeat every 35 cycles.
      @(negedge clk); #1;
      clear_mon(0);
      load[0] = 1'b1; data0 = 8'h55;
      for (int f = 0; f < 3; f++) wait_done(0, 100, "t6_done_seen");
      load[0] = 1'b0;
      check("t6_period", 32'(period[0]), 32'd35);
      repeat (50) @(negedge clk); #1;
      check("t6_done_count", 32'(ndone[0]), 32'd3);
      check("t6_frames", 32'(frames[0]), 32'd3);
      check("t6_bits", bits[0][23:0], 32'h555555);
      check("t6_rises", 32'(nbits[0]), 32'd24);
      check("t6_done_single", 32'(done_long[0]), 32'd0);
      check("t6_done_busy_low", 32'(done_busy[0]), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
